// File: rtl/sum_accumulator_pkg.sv
// Shared constants and state encoding for the stream-fed sum accumulator.
package sum_accumulator_pkg;

  localparam int   DATA_W   = 32;
  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  typedef enum logic {
    S_ACCUM = ST_ACCUM,
    S_HOLD  = ST_HOLD
  } acc_state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Operand stream in, result bundle out; slave is the accumulator side.
interface sum_accumulator_if
  import sum_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_carry;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_carry
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_carry
  );

endinterface

// File: rtl/n_bitadder.sv
// Plain N-bit combinational adder; the carry-out is recovered by the caller.
module n_bitadder
  import sum_accumulator_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] answer
);

  assign answer = input1 + input2;

endmodule

// File: rtl/sum_accumulator.sv
// Sums each in_last-terminated operand group and holds the result until taken.
//
//   state   | meaning
//   S_ACCUM | accepting beats, folding each into acc/cnt/cry
//   S_HOLD  | result presented on out_*, input stalled until out_ready
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sum_accumulator_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  acc_state_t        state;
  acc_state_t        state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] answer;
  logic [CNT_W-1:0]  cnt;
  logic              cry;
  logic              carry;
  logic              accum_rdy;
  logic              hold_vld;
  logic              beat_take;
  logic              res_take;

  n_bitadder #(
    .N (DATA_W)
  ) u_adder (
    .input1 (acc),
    .input2 (bus.in_data),
    .answer (answer)
  );

  // Unsigned wrap of the sum below the old value means bit 31 carried out.
  assign carry = (answer < acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accum_rdy = 1'b0;
    hold_vld  = 1'b0;
    case (state)
      S_ACCUM: begin
        accum_rdy = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_vld = 1'b1;
        if (bus.out_ready) begin
          state_nxt = S_ACCUM;
        end
      end
      default: state_nxt = S_ACCUM;
    endcase
  end

  assign beat_take = accum_rdy & bus.in_valid;
  assign res_take  = hold_vld & bus.out_ready;

  // The result handshake only clears; a new group starts on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      cry <= 1'b0;
    end else if (res_take) begin
      acc <= '0;
      cnt <= '0;
      cry <= 1'b0;
    end else if (beat_take) begin
      acc <= answer;
      cnt <= (&cnt) ? cnt : cnt + CNT_ONE;
      cry <= cry | carry;
    end
  end

  assign bus.in_ready  = accum_rdy & ~rst;
  assign bus.out_valid = hold_vld;
  assign bus.out_sum   = acc;
  assign bus.out_count = cnt;
  assign bus.out_carry = cry;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench: drivers queue group-level expectations, monitors pop on each result handshake.
module tb_sum_accumulator;
  import sum_accumulator_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic        cry;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sum_accumulator_if #(.CNT_W(8)) bus8 ();
  sum_accumulator_if #(.CNT_W(2)) bus2 ();

  sum_accumulator #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  sum_accumulator #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   checks   = 0;
  int   failures = 0;
  int   rmode    = 1;   // 0 random out_ready, 1 always ready, 2 stalled
  exp_t q8[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Group result from the arithmetic definition: exact total, then reduce.
  function automatic exp_t model(input logic [31:0] beats[$], input int unsigned cmax);
    exp_t        e;
    logic [63:0] tot = 64'd0;
    foreach (beats[i]) tot += {32'd0, beats[i]};
    e.sum = tot[31:0];
    e.cry = (tot >= 64'h1_0000_0000);
    e.cnt = (beats.size() > cmax) ? cmax : beats.size();
    return e;
  endfunction

  task automatic send_beat(input logic [31:0] d, input bit last, input int idle, output int waits);
    repeat (idle) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
    end
    waits = 0;
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_data  = d;
    bus8.in_last  = last;
    while (!bus8.in_ready) begin
      waits++;
      if (waits > 300) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_group(input logic [31:0] beats[$], input int maxidle, output int first_wait);
    int w;
    first_wait = 0;
    foreach (beats[i]) begin
      send_beat(beats[i], (i == beats.size() - 1), $urandom_range(0, maxidle), w);
      if (i == 0) first_wait = w;
    end
    q8.push_back(model(beats, 255));
  endtask

  task automatic drain();
    @(negedge clk);
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 400 && q8.size() != 0; i++) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rmode == 0)      bus8.out_ready = 1'($urandom_range(0, 1));
    else if (rmode == 1) bus8.out_ready = 1'b1;
    else                 bus8.out_ready = 1'b0;
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("out_sum",   bus8.out_sum, e.sum);
        check("out_count", 32'(bus8.out_count), e.cnt);
        check("out_carry", 32'(bus8.out_carry), 32'(e.cry));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bus2.out_ready = 1'b1;
    if (!rst && bus2.out_valid) begin
      if (q2.size() == 0) begin
        check("unexpected_result2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("sat_sum",   bus2.out_sum, e.sum);
        check("sat_count", 32'(bus2.out_count), e.cnt);
        check("sat_carry", 32'(bus2.out_carry), 32'(e.cry));
      end
    end
  end

  initial begin
    logic [31:0] bq[$];
    int          w;
    exp_t        e;

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus8.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_out_sum",   bus8.out_sum, 32'd0);
    check("rst_out_count", 32'(bus8.out_count), 32'd0);
    check("rst_out_carry", 32'(bus8.out_carry), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus8.in_ready), 32'd1);

    // basic group, result valid for exactly one cycle with out_ready high
    bq = {32'd1209, 32'd4565};
    send_group(bq, 0, w);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("basic_valid_up", 32'(bus8.out_valid), 32'd1);
    @(negedge clk);
    check("basic_valid_down", 32'(bus8.out_valid), 32'd0);

    bq = {32'hFFFF_FFFF, 32'd2};
    send_group(bq, 0, w);
    drain();

    // backpressure: result held, input stalled even with in_valid high
    @(posedge clk);
    rmode = 2;
    send_beat(32'd7, 1'b1, 0, w);
    bq = {32'd7};
    q8.push_back(model(bq, 255));
    @(negedge clk);
    bus8.in_data = 32'd99;
    bus8.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus8.in_ready), 32'd0);
      check("bp_out_sum",   bus8.out_sum, 32'd7);
      check("bp_out_count", 32'(bus8.out_count), 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    rmode = 1;
    bq = {32'd99};
    q8.push_back(model(bq, 255));
    @(negedge clk);
    @(negedge clk);
    check("bp_next_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("bp_next_taken", 32'(bus8.out_valid), 32'd1);
    drain();

    // reset mid-group discards the partial sum asynchronously
    send_beat(32'd10, 1'b0, 0, w);
    send_beat(32'd20, 1'b0, 0, w);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_sum",   bus8.out_sum, 32'd0);
    check("mid_rst_count", 32'(bus8.out_count), 32'd0);
    check("mid_rst_ready", 32'(bus8.in_ready), 32'd0);
    check("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_carry", 32'(bus8.out_carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bq = {32'd3};
    send_group(bq, 0, w);
    drain();

    // back-to-back groups: exactly one stalled cycle between them
    bq = {32'd100, 32'd200};
    send_group(bq, 0, w);
    bq = {32'd5};
    send_group(bq, 0, w);
    check("b2b_hold_cycles", w, 32'd1);
    drain();

    // long group saturates the 8-bit count and wraps the sum
    bq = {};
    repeat (260) bq.push_back(32'h0100_0000);
    send_group(bq, 0, w);
    drain();

    rmode = 0;
    repeat (40) begin
      bq = {};
      repeat ($urandom_range(1, 6)) begin
        case ($urandom_range(0, 2))
          0:       bq.push_back(32'($urandom_range(0, 1000)));
          1:       bq.push_back(32'hF000_0000 | $urandom);
          default: bq.push_back($urandom);
        endcase
      end
      send_group(bq, 2, w);
    end
    @(posedge clk);
    rmode = 1;
    drain();

    // CNT_W=2 instance: five beats of 1 saturate the count at 3
    bq = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    e = model(bq, 3);
    q2.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1;
      bus2.in_data  = 32'd1;
      bus2.in_last  = (i == 4);
      check("sat_in_ready", 32'(bus2.in_ready), 32'd1);
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
    check("q2_drained", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
